ni_reorder_tracker: RTL and testbench
=====================================

NI_REORDER_TRACKER -- requirements
Module: ni_reorder_tracker

Interface
REQ-001 SHALL have parameter TIDS_M, default 16, number of AXI transaction IDs at the master side.
REQ-002 SHALL have parameter EXT_SLAVES, default 4, number of external slaves (destinations).
REQ-003 SHALL have parameter MAX_PENDING, default 8, max outstanding transactions per TID per op (≥1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port iss_valid, input, 1, request path offers a new AXI request.
REQ-007 SHALL have port iss_op, input, 2, one-hot {read,write}.
REQ-008 SHALL have port iss_tid, input, log2c_1if1(TIDS_M), binary TID.
REQ-009 SHALL have port iss_dst, input, log2c_1if1(EXT_SLAVES), destination slave index.
REQ-010 SHALL have port iss_ready, output, 1, request may issue; issue fires when iss_valid & iss_ready.
REQ-011 SHALL have port ret_valid, input, 1, completion pulse from response path (reorder_return).
REQ-012 SHALL have port ret_op, input, 2, one-hot {read,write} of completion (reorder_return_op).
REQ-013 SHALL have port ret_tid, input, log2c_1if1(TIDS_M), completed TID (reorder_return_tid).
REQ-014 SHALL have port busy, output, 1, any outstanding counter nonzero.
REQ-015 SHALL have port err_underflow, output, 1, sticky flag: completion received with zero outstanding.
REQ-016 SHALL have port stall_cnt, output, 32, count of cycles iss_valid & !iss_ready.

Function
REQ-017 SHALL keep independent read and write tables, each with per-TID counter cnt (0..MAX_PENDING) and destination register dst.
REQ-018 SHALL drive iss_ready combinationally = selected-op table entry for iss_tid has (cnt==0) or (dst==iss_dst and cnt<MAX_PENDING); no dependency on iss_valid.
REQ-019 SHALL, on issue fire, increment the selected cnt next cycle and load dst with iss_dst when cnt was 0.
REQ-020 SHALL, on ret_valid, decrement cnt of ret_op table entry ret_tid next cycle; dst unchanged.
REQ-021 SHALL, on issue fire and ret_valid to the same op and TID in one cycle, leave cnt unchanged; if cnt was 0 (underflow case), cnt becomes 1, dst loads iss_dst, and err_underflow sets.
REQ-022 SHALL, on ret_valid with cnt==0 (no simultaneous issue to that entry), hold cnt at 0 and set err_underflow, which stays set until reset.
REQ-023 SHALL ignore iss_op or ret_op values not one-hot (no state change, no error).
REQ-024 SHALL saturate cnt at MAX_PENDING; iss_ready is low there so increment never overflows.
REQ-025 SHALL drive busy combinationally from registered counters (OR of all cnt!=0).
REQ-026 SHALL increment stall_cnt each cycle iss_valid & !iss_ready, wrapping 0xFFFFFFFF→0.
REQ-027 SHALL produce zero-latency readiness (combinational) and one-cycle counter update latency.

Reset
REQ-028 SHALL, while rst==0 at a clock edge, clear all cnt, dst, err_underflow, stall_cnt; outputs after reset: iss_ready=1, busy=0, err_underflow=0, stall_cnt=0.
REQ-029 SHALL treat reset mid-operation as discarding all outstanding state; issues/returns in the reset cycle have no effect.

Configuration
REQ-030 SHALL compile stall_cnt logic only when macro NI_REORDER_STALL_CNT_EN is defined; otherwise stall_cnt port remains and is tied to 0.

Verification
REQ-031 Reset, then read issue tid=3 dst=2 -> next cycle busy=1, read cnt[3]=1, iss_ready=1 for read tid=3 dst=2.
REQ-032 Outstanding read tid=3 dst=2, offer read tid=3 dst=1 -> iss_ready=0, stall_cnt increments per cycle; after ret_valid read tid=3, iss_ready=1 next cycle.
REQ-033 Eight read issues tid=5 dst=0 (MAX_PENDING=8) -> ninth offer iss_ready=0; one return -> iss_ready=1.
REQ-034 Write cnt[1]=1, same-cycle issue write tid=1 dst=same and return write tid=1 -> cnt stays 1, busy=1.
REQ-035 Return write tid=7 with cnt=0 -> err_underflow=1 next cycle and held; cnt stays 0; cleared only by rst=0.
REQ-036 Read tid=2 dst=1 outstanding, issue write tid=2 dst=3 -> iss_ready=1 (tables independent).

Source files
------------

// File: rtl/ni_reorder_tracker.sv
// ni_reorder_tracker: per-TID outstanding read/write tracker that restricts issue to one destination per TID.
// Optional macro NI_REORDER_STALL_CNT_EN builds the stall cycle counter; otherwise stall_cnt is tied to 0.
module ni_reorder_tracker #(
    parameter int TIDS_M = 16,
    parameter int EXT_SLAVES = 4,
    parameter int MAX_PENDING = 8,
    localparam int TW = TIDS_M > 1 ? $clog2(TIDS_M) : 1,
    localparam int DW = EXT_SLAVES > 1 ? $clog2(EXT_SLAVES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic [1:0]    iss_op,
    input  logic [TW-1:0] iss_tid,
    input  logic [DW-1:0] iss_dst,
    output logic          iss_ready,
    input  logic          ret_valid,
    input  logic [1:0]    ret_op,
    input  logic [TW-1:0] ret_tid,
    output logic          busy,
    output logic          err_underflow,
    output logic [31:0]   stall_cnt
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    // Table index 1 is read, 0 is write, matching the one-hot op bit positions.
    logic [CW-1:0] cnt   [2][TIDS_M];
    logic [CW-1:0] cnt_n [2][TIDS_M];
    logic [DW-1:0] dst   [2][TIDS_M];
    logic [DW-1:0] dst_n [2][TIDS_M];
    logic          iss_oh, ret_oh, iss_fire, inc, dec, uf;
    logic [CW-1:0] cur_cnt;
    logic [DW-1:0] cur_dst;

    assign iss_oh    = iss_op == 2'b01 || iss_op == 2'b10;
    assign ret_oh    = ret_op == 2'b01 || ret_op == 2'b10;
    assign cur_cnt   = cnt[iss_op[1]][iss_tid];
    assign cur_dst   = dst[iss_op[1]][iss_tid];
    assign iss_ready = cur_cnt == '0 || (cur_dst == iss_dst && cur_cnt < CW'(MAX_PENDING));
    assign iss_fire  = iss_valid && iss_ready;

    always_comb begin
        cnt_n = cnt;
        dst_n = dst;
        uf    = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        busy  = 1'b0;
        for (int o = 0; o < 2; o++) begin
            for (int t = 0; t < TIDS_M; t++) begin
                inc  = iss_fire && iss_oh && iss_op[o] && iss_tid == TW'(t);
                dec  = ret_valid && ret_oh && ret_op[o] && ret_tid == TW'(t);
                uf   = uf | (dec && cnt[o][t] == '0);
                busy = busy | (cnt[o][t] != '0);
                dst_n[o][t] = inc && cnt[o][t] == '0 ? iss_dst : dst[o][t];
                // A return against an empty entry cannot cancel a same-cycle issue.
                cnt_n[o][t] = inc && (!dec || cnt[o][t] == '0) ? cnt[o][t] + 1'b1 :
                              dec && !inc && cnt[o][t] != '0   ? cnt[o][t] - 1'b1 : cnt[o][t];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < 2; o++) begin
                for (int t = 0; t < TIDS_M; t++) begin
                    cnt[o][t] <= '0;
                    dst[o][t] <= '0;
                end
            end
            err_underflow <= 1'b0;
        end else begin
            cnt <= cnt_n;
            dst <= dst_n;
            if (uf) err_underflow <= 1'b1;
        end
    end

`ifdef NI_REORDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) stall_cnt <= '0;
        else if (iss_valid && !iss_ready) stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ni_reorder_tracker.sv
// tb_ni_reorder_tracker: directed self-checking bench for ni_reorder_tracker with default parameters.
module tb_ni_reorder_tracker;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b01;
`ifdef NI_REORDER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iss_valid = 1'b0;
    logic [1:0]  iss_op = 2'b00;
    logic [3:0]  iss_tid = '0;
    logic [1:0]  iss_dst = '0;
    logic        iss_ready;
    logic        ret_valid = 1'b0;
    logic [1:0]  ret_op = 2'b00;
    logic [3:0]  ret_tid = '0;
    logic        busy;
    logic        err_underflow;
    logic [31:0] stall_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] stall_exp = '0;

    ni_reorder_tracker dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_tid(iss_tid), .iss_dst(iss_dst), .iss_ready(iss_ready),
        .ret_valid(ret_valid), .ret_op(ret_op), .ret_tid(ret_tid),
        .busy(busy), .err_underflow(err_underflow), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_iss(input logic v, input logic [1:0] op, input logic [3:0] tid, input logic [1:0] d);
        iss_valid = v; iss_op = op; iss_tid = tid; iss_dst = d;
        #1;
    endtask

    task automatic drive_ret(input logic v, input logic [1:0] op, input logic [3:0] tid);
        ret_valid = v; ret_op = op; ret_tid = tid;
        #1;
    endtask

    task automatic idle();
        drive_iss(1'b0, 2'b00, 4'd0, 2'd0);
        drive_ret(1'b0, 2'b00, 4'd0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        stall_exp = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_iss(1'b1, RD, 4'd3, 2'd2);
        drive_ret(1'b1, WR, 4'd9);
        step();
        step();
        rst = 1'b1;
        idle();
        drive_iss(1'b0, RD, 4'd3, 2'd1);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", iss_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err_underflow); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        stall_exp = '0;
    endtask

    task automatic test_basic();
        drive_iss(1'b1, RD, 4'd3, 2'd2);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_empty: got %0b expected 1", iss_ready); end
        step();
        drive_iss(1'b0, RD, 4'd3, 2'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_same_dst: got %0b expected 1", iss_ready); end
        drive_iss(1'b0, RD, 4'd3, 2'd1);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_other_dst: got %0b expected 0", iss_ready); end
    endtask

    task automatic test_stall();
        drive_iss(1'b1, RD, 4'd3, 2'd1);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b expected 0", iss_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            stall_exp = stall_exp + 1;
        end
        checks++; if (stall_cnt !== (STALL_EN ? stall_exp : 32'd0)) begin errors++; $display("FAIL stall_count3: got %0d expected %0d", stall_cnt, STALL_EN ? stall_exp : 32'd0); end
        drive_ret(1'b1, RD, 4'd3);
        step();
        stall_exp = stall_exp + 1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_after_ret: got %0b expected 1", iss_ready); end
        checks++; if (stall_cnt !== (STALL_EN ? stall_exp : 32'd0)) begin errors++; $display("FAIL stall_count4: got %0d expected %0d", stall_cnt, STALL_EN ? stall_exp : 32'd0); end
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_clear: got %0b expected 0", busy); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_iss(1'b1, RD, 4'd5, 2'd0);
            checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_issue%0d: got %0b expected 1", i, iss_ready); end
            step();
        end
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_ready_ninth: got %0b expected 0", iss_ready); end
        step();
        stall_exp = stall_exp + 1;
        checks++; if (stall_cnt !== (STALL_EN ? stall_exp : 32'd0)) begin errors++; $display("FAIL sat_stall: got %0d expected %0d", stall_cnt, STALL_EN ? stall_exp : 32'd0); end
        drive_iss(1'b0, RD, 4'd5, 2'd0);
        drive_ret(1'b1, RD, 4'd5);
        step();
        drive_ret(1'b0, RD, 4'd5);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_after_ret: got %0b expected 1", iss_ready); end
        drive_ret(1'b1, RD, 4'd5);
        for (int i = 0; i < 6; i++) step();
        drive_ret(1'b0, RD, 4'd5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy_one_left: got %0b expected 1", busy); end
        drive_ret(1'b1, RD, 4'd5);
        step();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_busy_drained: got %0b expected 0", busy); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sat_err: got %0b expected 0", err_underflow); end
    endtask

    task automatic test_simultaneous();
        drive_iss(1'b1, WR, 4'd1, 2'd2);
        step();
        idle();
        drive_iss(1'b1, WR, 4'd1, 2'd2);
        drive_ret(1'b1, WR, 4'd1);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %0b expected 1", iss_ready); end
        step();
        idle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_busy: got %0b expected 1", busy); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL simul_err: got %0b expected 0", err_underflow); end
        drive_ret(1'b1, WR, 4'd1);
        step();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy_drained: got %0b expected 0", busy); end
    endtask

    task automatic test_independent();
        drive_iss(1'b1, RD, 4'd2, 2'd1);
        step();
        drive_iss(1'b0, WR, 4'd2, 2'd3);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL indep_write_ready: got %0b expected 1", iss_ready); end
        drive_iss(1'b0, RD, 4'd2, 2'd3);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL indep_read_ready: got %0b expected 0", iss_ready); end
        drive_ret(1'b1, RD, 4'd2);
        step();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL indep_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_invalid_op();
        drive_iss(1'b1, 2'b11, 4'd4, 2'd0);
        drive_ret(1'b1, 2'b00, 4'd4);
        step();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL invop_busy: got %0b expected 0", busy); end
        drive_ret(1'b1, 2'b11, 4'd9);
        step();
        idle();
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL invop_err: got %0b expected 0", err_underflow); end
    endtask

    task automatic test_underflow();
        drive_ret(1'b1, WR, 4'd7);
        step();
        idle();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %0b expected 1", err_underflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uf_busy: got %0b expected 0", busy); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %0b expected 1", err_underflow); end
        drive_iss(1'b0, WR, 4'd7, 2'd3);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL uf_cnt_zero: got %0b expected 1", iss_ready); end
        do_reset();
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_reset_clear: got %0b expected 0", err_underflow); end
    endtask

    task automatic test_simul_underflow();
        drive_iss(1'b1, WR, 4'd6, 2'd1);
        drive_ret(1'b1, WR, 4'd6);
        step();
        idle();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL suf_err: got %0b expected 1", err_underflow); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL suf_busy: got %0b expected 1", busy); end
        drive_iss(1'b0, WR, 4'd6, 2'd2);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL suf_dst_loaded: got %0b expected 0", iss_ready); end
        drive_ret(1'b1, WR, 4'd6);
        step();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL suf_busy_drained: got %0b expected 0", busy); end
    endtask

    task automatic test_mid_reset();
        drive_iss(1'b1, RD, 4'd0, 2'd0);
        step();
        rst = 1'b0;
        drive_iss(1'b1, WR, 4'd0, 2'd0);
        step();
        rst = 1'b1;
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", err_underflow); end
        drive_iss(1'b0, RD, 4'd0, 2'd3);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b expected 1", iss_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_saturate();
        test_simultaneous();
        test_independent();
        test_invalid_op();
        test_underflow();
        test_simul_underflow();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
